// File: rtl/id_ex_alu_ctrl_pkg.sv
// ============================================================================
// Module : alu_ctrl_pkg
// Brief  : Shared ALU select codes, ALUOp encodings and funct constants.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

endpackage

`default_nettype wire

// File: rtl/id_ex_alu_ctrl_if.sv
// ============================================================================
// Module : id_ex_alu_ctrl_if
// Brief  : ID-side control inputs and EX-side registered ALU control outputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ex_alu_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             id_valid;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic             stall;
  logic             flush;
  logic             ex_valid;
  logic [2:0]       ex_alu_ctrl;
  logic             ex_illegal;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output id_valid, alu_op, funct, stall, flush,
    input  ex_valid, ex_alu_ctrl, ex_illegal, err_cnt
  );

  modport slave (
    input  id_valid, alu_op, funct, stall, flush,
    output ex_valid, ex_alu_ctrl, ex_illegal, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_alu_ctrl_dec.sv
// ============================================================================
// Module : alu_ctrl_dec
// Brief  : Combinational (alu_op, funct) -> (ALU code, illegal) decoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ctrl_dec
  import alu_ctrl_pkg::*;
(
  input  wire logic [1:0] i_alu_op,
  input  wire logic [5:0] i_funct,
  output logic      [2:0] o_code,
  output logic            o_illegal
);

  // Unsupported encodings fall back to ADD so EX never sees an undefined code.
  always_comb begin
    o_code    = ALU_ADD;
    o_illegal = 1'b0;
    case (i_alu_op)
      OP_ADD: o_code = ALU_ADD;
      OP_SUB: o_code = ALU_SUB;
      OP_RTYPE: begin
        case (i_funct)
          F_ADD:   o_code = ALU_ADD;
          F_SUB:   o_code = ALU_SUB;
          F_AND:   o_code = ALU_AND;
          F_OR:    o_code = ALU_OR;
          F_SLT:   o_code = ALU_SLT;
          default: o_illegal = 1'b1;
        endcase
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_alu_ctrl.sv
// ============================================================================
// Module : id_ex_alu_ctrl
// Brief  : ID/EX stage register for the ALU select code with stall/flush and
//          an optional saturating illegal-decode counter (ALU_CTRL_ERRCNT_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  id_ex_alu_ctrl_if.slave   bus
);

  logic [2:0] w_code;
  logic       w_illegal;
  logic       w_load;
  logic       r_valid;
  logic [2:0] r_ctrl;
  logic       r_illegal;

  alu_ctrl_dec u_dec (
    .i_alu_op  (bus.alu_op),
    .i_funct   (bus.funct),
    .o_code    (w_code),
    .o_illegal (w_illegal)
  );

  assign w_load = !bus.flush && !bus.stall;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_valid   <= 1'b0;
      r_ctrl    <= ALU_ADD;
      r_illegal <= 1'b0;
    end else if (!bus.stall) begin
      r_valid   <= bus.id_valid;
      r_ctrl    <= w_code;
      r_illegal <= w_illegal & bus.id_valid;
    end
  end

  assign bus.ex_valid    = r_valid;
  assign bus.ex_alu_ctrl = r_ctrl;
  assign bus.ex_illegal  = r_illegal;

`ifdef ALU_CTRL_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  // Saturates at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_load && bus.id_valid && w_illegal && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_alu_ctrl.sv
// ============================================================================
// Module : tb_id_ex_alu_ctrl
// Brief  : Directed plus randomized checks of id_ex_alu_ctrl against a model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_alu_ctrl;

  localparam int CNT_W = 2;
`ifdef ALU_CTRL_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_alu_ctrl_if #(.CNT_W(CNT_W)) bus_if ();

  id_ex_alu_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: legal R-type functs and the codes they select.
  int fn_tab   [5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
  int code_tab [5] = '{2, 6, 0, 1, 7};

  int m_valid;
  int m_code;
  int m_ill;
  int m_cnt;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic ref_decode(input int op, input int fn, output int code, output int ill);
    code = 2;
    ill  = 0;
    if (op == 0) code = 2;
    else if (op == 1) code = 6;
    else if (op == 3) ill = 1;
    else begin
      ill = 1;
      foreach (fn_tab[k]) if (fn_tab[k] == fn) begin
        code = code_tab[k];
        ill  = 0;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit v, input int op, input int fn,
                     input bit st, input bit fl);
    int code, ill;
    rst             = r;
    bus_if.id_valid = v;
    bus_if.alu_op   = op[1:0];
    bus_if.funct    = fn[5:0];
    bus_if.stall    = st;
    bus_if.flush    = fl;
    @(posedge clk);
    ref_decode(op, fn, code, ill);
    if (r) begin
      m_valid = 0; m_code = 2; m_ill = 0; m_cnt = 0;
    end else if (fl) begin
      m_valid = 0; m_code = 2; m_ill = 0;
    end else if (!st) begin
      m_valid = int'(v);
      m_code  = code;
      m_ill   = (v && ill != 0) ? 1 : 0;
      if (ERRCNT && v && ill != 0 && m_cnt < CNT_MAX) m_cnt++;
    end
    @(negedge clk);
    check_val("ex_valid",    int'(bus_if.ex_valid),    m_valid);
    check_val("ex_alu_ctrl", int'(bus_if.ex_alu_ctrl), m_code);
    check_val("ex_illegal",  int'(bus_if.ex_illegal),  m_ill);
    check_val("err_cnt",     int'(bus_if.err_cnt),     m_cnt);
  endtask

  initial begin
    bus_if.id_valid = 1'b0;
    bus_if.alu_op   = 2'b00;
    bus_if.funct    = 6'h00;
    bus_if.stall    = 1'b0;
    bus_if.flush    = 1'b0;

    // Reset for two cycles
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // R-type sweep of the legal functs
    foreach (fn_tab[k]) cyc(0, 1, 2, fn_tab[k], 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);

    // Illegal encodings, then illegal with id_valid low
    cyc(0, 1, 2, 32'h27, 0, 0);
    cyc(0, 1, 3, 32'h20, 0, 0);
    cyc(0, 0, 2, 32'h27, 0, 0);
    cyc(0, 0, 3, 32'h00, 0, 0);

    // Load SUB then stall while funct changes
    cyc(0, 1, 2, 32'h22, 0, 0);
    cyc(0, 1, 2, 32'h24, 1, 0);
    cyc(0, 1, 2, 32'h25, 1, 0);
    cyc(0, 1, 3, 32'h3F, 1, 0);
    cyc(0, 1, 2, 32'h2A, 1, 1);

    // Back-to-back illegal loads to drive the counter into saturation
    for (int i = 0; i < 5; i++) cyc(0, 1, 3, i, 0, 0);
    cyc(0, 1, 2, 32'h27, 1, 0);
    cyc(0, 1, 2, 32'h27, 0, 1);

    // Reset during stall and during flush
    cyc(1, 1, 2, 32'h20, 1, 0);
    cyc(1, 1, 2, 32'h20, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int fn;
      fn = ($urandom_range(1, 0) == 1) ? fn_tab[$urandom_range(4, 0)]
                                       : int'($urandom_range(63, 0));
      cyc($urandom_range(40, 0) == 0,
          $urandom_range(3, 0) != 0,
          int'($urandom_range(3, 0)),
          fn,
          $urandom_range(3, 0) == 0,
          $urandom_range(7, 0) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
